// File: rtl/stream_compare_multilink.sv
// stream_compare_multilink
//   Multi-lane lockstep comparator for two AXI-Stream inputs. Each beat is
//   split into NLINKS lanes of LINK_WIDTH bits and compared under a per-lane
//   enable mask. Keeps saturating word/error/per-lane counters, captures the
//   first failing word and drives a mode-selectable one-cycle trigger.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   S_AXIS_{0,1}_TDATA/TVALID       stream inputs (lane i at [i*LINK_WIDTH +: LINK_WIDTH])
//   S_AXIS_{0,1}_TREADY             both = TVALID_0 & TVALID_1
//   link_enable                     per-lane compare enable, sampled at acceptance
//   clear                           zero counters, sticky flag and first-error capture
//   latch                           snapshot counters into *_latched
//   trigger_mode                    0/3 off, 1 every error word, 2 first error word only
//   mismatch, mismatch_sticky       trigger pulse and sticky error flag
//   word_count_latched, err_count_latched, lane_err_count_latched  snapshots
//   first_err_valid/index/lanes/data0/data1                         first-error capture
module stream_compare_multilink #(
  parameter int unsigned NLINKS         = 4,
  parameter int unsigned LINK_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned LANE_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NLINKS*LINK_WIDTH-1:0]       S_AXIS_0_TDATA,
  input  logic                               S_AXIS_0_TVALID,
  output logic                               S_AXIS_0_TREADY,
  input  logic [NLINKS*LINK_WIDTH-1:0]       S_AXIS_1_TDATA,
  input  logic                               S_AXIS_1_TVALID,
  output logic                               S_AXIS_1_TREADY,
  input  logic [NLINKS-1:0]                  link_enable,
  input  logic                               clear,
  input  logic                               latch,
  input  logic [1:0]                         trigger_mode,
  output logic                               mismatch,
  output logic                               mismatch_sticky,
  output logic [CNT_WIDTH-1:0]               word_count_latched,
  output logic [CNT_WIDTH-1:0]               err_count_latched,
  output logic [NLINKS*LANE_CNT_WIDTH-1:0]   lane_err_count_latched,
  output logic                               first_err_valid,
  output logic [CNT_WIDTH-1:0]               first_err_index,
  output logic [NLINKS-1:0]                  first_err_lanes,
  output logic [NLINKS*LINK_WIDTH-1:0]       first_err_data0,
  output logic [NLINKS*LINK_WIDTH-1:0]       first_err_data1
);

  localparam int unsigned DW = NLINKS * LINK_WIDTH;

  typedef enum logic [1:0] {
    TRIG_OFF   = 2'd0,
    TRIG_EVERY = 2'd1,
    TRIG_FIRST = 2'd2,
    TRIG_OFF3  = 2'd3
  } trig_mode_e;

  logic accept;
  assign accept          = S_AXIS_0_TVALID & S_AXIS_1_TVALID;
  assign S_AXIS_0_TREADY = accept;
  assign S_AXIS_1_TREADY = accept;

  // Stage 1: lane compare under the mask present at acceptance
  logic [NLINKS-1:0] lane_diff;
  always_comb begin
    lane_diff = '0;
    for (int unsigned i = 0; i < NLINKS; i++) begin
      lane_diff[i] = link_enable[i] &
                     (S_AXIS_0_TDATA[i*LINK_WIDTH +: LINK_WIDTH] !=
                      S_AXIS_1_TDATA[i*LINK_WIDTH +: LINK_WIDTH]);
    end
  end

  logic              s1_valid_q;
  logic [NLINKS-1:0] s1_diff_q;
  logic [DW-1:0]     s1_data0_q, s1_data1_q;

  // A beat accepted in the clear cycle still enters stage 1; the beat already
  // sitting in stage 1 is dropped by the stage-2 clear priority below.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_data0_q <= '0;
      s1_data1_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_diff_q  <= lane_diff;
        s1_data0_q <= S_AXIS_0_TDATA;
        s1_data1_q <= S_AXIS_1_TDATA;
      end
    end
  end

  // Stage 2: counters, sticky flag, first-error capture, trigger
  logic [CNT_WIDTH-1:0]      word_q, word_d, err_q, err_d;
  logic [LANE_CNT_WIDTH-1:0] lane_q [NLINKS];
  logic [LANE_CNT_WIDTH-1:0] lane_d [NLINKS];
  logic                      sticky_q, sticky_d;
  logic                      mis_q, mis_d;
  logic                      fev_q, fev_d;
  logic [CNT_WIDTH-1:0]      fidx_q, fidx_d;
  logic [NLINKS-1:0]         flanes_q, flanes_d;
  logic [DW-1:0]             fd0_q, fd0_d, fd1_q, fd1_d;
  logic                      err_word;
  trig_mode_e                mode;

  assign err_word = s1_valid_q & (|s1_diff_q);
  assign mode     = trig_mode_e'(trigger_mode);

  always_comb begin
    word_d   = word_q;
    err_d    = err_q;
    lane_d   = lane_q;
    sticky_d = sticky_q;
    mis_d    = 1'b0;
    fev_d    = fev_q;
    fidx_d   = fidx_q;
    flanes_d = flanes_q;
    fd0_d    = fd0_q;
    fd1_d    = fd1_q;
    if (clear) begin
      word_d   = '0;
      err_d    = '0;
      for (int unsigned i = 0; i < NLINKS; i++) lane_d[i] = '0;
      sticky_d = 1'b0;
      fev_d    = 1'b0;
      fidx_d   = '0;
      flanes_d = '0;
      fd0_d    = '0;
      fd1_d    = '0;
    end else if (s1_valid_q) begin
      if (word_q != '1) word_d = word_q + CNT_WIDTH'(1);
      if (err_word) begin
        if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
        sticky_d = 1'b1;
        for (int unsigned i = 0; i < NLINKS; i++) begin
          if (s1_diff_q[i] && (lane_q[i] != '1))
            lane_d[i] = lane_q[i] + LANE_CNT_WIDTH'(1);
        end
        if (!fev_q) begin
          fev_d    = 1'b1;
          fidx_d   = word_q;
          flanes_d = s1_diff_q;
          fd0_d    = s1_data0_q;
          fd1_d    = s1_data1_q;
        end
        case (mode)
          TRIG_EVERY: mis_d = 1'b1;
          TRIG_FIRST: mis_d = ~fev_q;
          default:    mis_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= '0;
      err_q    <= '0;
      for (int unsigned i = 0; i < NLINKS; i++) lane_q[i] <= '0;
      sticky_q <= 1'b0;
      mis_q    <= 1'b0;
      fev_q    <= 1'b0;
      fidx_q   <= '0;
      flanes_q <= '0;
      fd0_q    <= '0;
      fd1_q    <= '0;
    end else begin
      word_q   <= word_d;
      err_q    <= err_d;
      lane_q   <= lane_d;
      sticky_q <= sticky_d;
      mis_q    <= mis_d;
      fev_q    <= fev_d;
      fidx_q   <= fidx_d;
      flanes_q <= flanes_d;
      fd0_q    <= fd0_d;
      fd1_q    <= fd1_d;
    end
  end

  // Snapshot takes the current register values, so a simultaneous clear
  // still yields the pre-clear counts.
  logic [CNT_WIDTH-1:0]             word_lat_q, err_lat_q;
  logic [NLINKS*LANE_CNT_WIDTH-1:0] lane_lat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_lat_q <= '0;
      err_lat_q  <= '0;
      lane_lat_q <= '0;
    end else if (latch) begin
      word_lat_q <= word_q;
      err_lat_q  <= err_q;
      for (int unsigned i = 0; i < NLINKS; i++)
        lane_lat_q[i*LANE_CNT_WIDTH +: LANE_CNT_WIDTH] <= lane_q[i];
    end
  end

  assign mismatch               = mis_q;
  assign mismatch_sticky        = sticky_q;
  assign word_count_latched     = word_lat_q;
  assign err_count_latched      = err_lat_q;
  assign lane_err_count_latched = lane_lat_q;
  assign first_err_valid        = fev_q;
  assign first_err_index        = fidx_q;
  assign first_err_lanes        = flanes_q;
  assign first_err_data0        = fd0_q;
  assign first_err_data1        = fd1_q;

endmodule

// File: tb/tb_stream_compare_multilink.sv
module tb_stream_compare_multilink;

  localparam int NL  = 4;
  localparam int LW  = 32;
  localparam int CW  = 12;
  localparam int LCW = 8;
  localparam int DW  = NL * LW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     d0 = '0, d1 = '0;
  logic              v0 = 1'b0, v1 = 1'b0;
  logic              r0, r1;
  logic [NL-1:0]     en = '1;
  logic              clear = 1'b0, latch = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              mismatch, sticky, fev;
  logic [CW-1:0]     wlat, elat, fidx;
  logic [NL*LCW-1:0] llat;
  logic [NL-1:0]     flanes;
  logic [DW-1:0]     fd0, fd1;

  stream_compare_multilink #(
    .NLINKS(NL), .LINK_WIDTH(LW), .CNT_WIDTH(CW), .LANE_CNT_WIDTH(LCW)
  ) dut (
    .clk(clk), .reset(reset),
    .S_AXIS_0_TDATA(d0), .S_AXIS_0_TVALID(v0), .S_AXIS_0_TREADY(r0),
    .S_AXIS_1_TDATA(d1), .S_AXIS_1_TVALID(v1), .S_AXIS_1_TREADY(r1),
    .link_enable(en), .clear(clear), .latch(latch), .trigger_mode(mode),
    .mismatch(mismatch), .mismatch_sticky(sticky),
    .word_count_latched(wlat), .err_count_latched(elat),
    .lane_err_count_latched(llat),
    .first_err_valid(fev), .first_err_index(fidx), .first_err_lanes(flanes),
    .first_err_data0(fd0), .first_err_data1(fd1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    logic [NL-1:0] diff;
    logic [DW-1:0] a, b;
  } beat_t;

  beat_t         pipe[$];
  int            edge_n = 0;
  bit            live = 0;
  longint        m_words, m_errs;
  longint        m_lane[NL];
  bit            m_sticky, m_mis, m_fev;
  logic [CW-1:0] m_fidx, m_wlat, m_elat;
  logic [NL*LCW-1:0] m_llat;
  logic [NL-1:0] m_flanes;
  logic [DW-1:0] m_fd0, m_fd1;

  function automatic logic [CW-1:0] satc(input longint x);
    longint mx = (longint'(1) << CW) - 1;
    return (x > mx) ? CW'(mx) : CW'(x);
  endfunction

  function automatic logic [LCW-1:0] satl(input longint x);
    longint mx = (longint'(1) << LCW) - 1;
    return (x > mx) ? LCW'(mx) : LCW'(x);
  endfunction

  task automatic model_zero();
    m_words = 0; m_errs = 0;
    for (int i = 0; i < NL; i++) m_lane[i] = 0;
    m_sticky = 0; m_fev = 0; m_fidx = '0; m_flanes = '0; m_fd0 = '0; m_fd1 = '0;
  endtask

  always @(posedge clk) begin
    beat_t b;
    edge_n++;
    live = 1;
    m_mis = 0;
    if (reset) begin
      model_zero();
      m_wlat = '0; m_elat = '0; m_llat = '0;
      pipe.delete();
    end else begin
      if (latch) begin
        m_wlat = satc(m_words);
        m_elat = satc(m_errs);
        for (int i = 0; i < NL; i++) m_llat[i*LCW +: LCW] = satl(m_lane[i]);
      end
      if (pipe.size() > 0 && pipe[0].due == edge_n) begin
        b = pipe.pop_front();
        if (!clear) begin
          if (b.diff != '0) begin
            if (mode == 2'd1) m_mis = 1;
            if (mode == 2'd2 && !m_fev) m_mis = 1;
            if (!m_fev) begin
              m_fev = 1; m_fidx = satc(m_words); m_flanes = b.diff;
              m_fd0 = b.a; m_fd1 = b.b;
            end
            m_errs++;
            m_sticky = 1;
            for (int i = 0; i < NL; i++) if (b.diff[i]) m_lane[i]++;
          end
          m_words++;
        end
      end
      if (clear) model_zero();
      if (v0 && v1) begin
        b.due = edge_n + 1;
        b.a = d0;
        b.b = d1;
        for (int i = 0; i < NL; i++)
          b.diff[i] = en[i] && (d0[i*LW +: LW] != d1[i*LW +: LW]);
        pipe.push_back(b);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (live) begin
      if (mismatch === 1'b1) pulses++;
      chk("tready0", {127'b0, r0}, {127'b0, v0 & v1});
      chk("tready1", {127'b0, r1}, {127'b0, v0 & v1});
      chk("mismatch", {127'b0, mismatch}, {127'b0, m_mis});
      chk("sticky", {127'b0, sticky}, {127'b0, m_sticky});
      chk("first_err_valid", {127'b0, fev}, {127'b0, m_fev});
      chk("first_err_index", DW'(fidx), DW'(m_fidx));
      chk("first_err_lanes", DW'(flanes), DW'(m_flanes));
      chk("first_err_data0", fd0, m_fd0);
      chk("first_err_data1", fd1, m_fd1);
      chk("word_count_latched", DW'(wlat), DW'(m_wlat));
      chk("err_count_latched", DW'(elat), DW'(m_elat));
      chk("lane_err_count_latched", DW'(llat), DW'(m_llat));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] mk(input int k);
    logic [DW-1:0] w;
    for (int j = 0; j < NL; j++) w[j*LW +: LW] = {16'(k), 8'(j), 8'h5A};
    return w;
  endfunction

  function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] w, input logic [NL-1:0] lanes);
    logic [DW-1:0] r = w;
    for (int j = 0; j < NL; j++) if (lanes[j]) r[j*LW +: LW] = ~w[j*LW +: LW];
    return r;
  endfunction

  task automatic step(input logic a_v, input logic b_v, input logic [DW-1:0] a_d,
                      input logic [DW-1:0] b_d, input logic clr, input logic lat);
    v0 = a_v; v1 = b_v; d0 = a_d; d1 = b_d; clear = clr; latch = lat;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; clear = 1'b0; latch = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic beat(input int k, input logic [NL-1:0] bad);
    step(1'b1, 1'b1, mk(k), corrupt(mk(k), bad), 1'b0, 1'b0);
  endtask

  task automatic settle_latch();
    idle(3);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_word_latched", DW'(wlat), '0);
    chk("reset_first_err_valid", {127'b0, fev}, '0);
    chk("reset_mismatch", {127'b0, mismatch}, '0);

    // identical streams
    mode = 2'd1; en = 4'hF; pulses = 0;
    for (int k = 0; k < 100; k++) beat(k, 4'b0000);
    settle_latch();
    chk("t1_words", DW'(wlat), DW'(100));
    chk("t1_errs", DW'(elat), DW'(0));
    chk("t1_pulses", DW'(pulses), DW'(0));
    chk("t1_fev", {127'b0, fev}, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("t1_latched_hold_after_clear", DW'(wlat), DW'(100));

    // single lane-2 error at word 5, mode 1
    pulses = 0;
    for (int k = 0; k < 10; k++) beat(k, (k == 5) ? 4'b0100 : 4'b0000);
    settle_latch();
    chk("t2_pulses", DW'(pulses), DW'(1));
    chk("t2_index", DW'(fidx), DW'(5));
    chk("t2_lanes", DW'(flanes), DW'(4'b0100));
    chk("t2_lane2", DW'(llat[2*LCW +: LCW]), DW'(1));
    chk("t2_errs", DW'(elat), DW'(1));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // lanes 1 and 3 bad on words 3,4,7, lane 3 masked, mode 2
    mode = 2'd2; en = 4'b0111; pulses = 0;
    for (int k = 0; k < 10; k++) beat(k, (k == 3 || k == 4 || k == 7) ? 4'b1010 : 4'b0000);
    settle_latch();
    chk("t3_pulses", DW'(pulses), DW'(1));
    chk("t3_errs", DW'(elat), DW'(3));
    chk("t3_lane1", DW'(llat[1*LCW +: LCW]), DW'(3));
    chk("t3_lane3", DW'(llat[3*LCW +: LCW]), DW'(0));
    chk("t3_lanes", DW'(flanes), DW'(4'b0010));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // stream 1 valid every other cycle
    mode = 2'd1; en = 4'hF;
    for (int k = 0; k < 20; k++) step(1'b1, (k % 2) == 0, mk(k), mk(k), 1'b0, 1'b0);
    settle_latch();
    chk("t4_words", DW'(wlat), DW'(10));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // lane counter saturation, mode 0
    mode = 2'd0; pulses = 0;
    for (int k = 0; k < (1 << LCW) + 3; k++) beat(k, 4'b0001);
    settle_latch();
    chk("t5_lane0_sat", DW'(llat[0 +: LCW]), DW'(8'hFF));
    chk("t5_errs", DW'(elat), DW'((1 << LCW) + 3));
    chk("t5_words", DW'(wlat), DW'((1 << LCW) + 3));
    chk("t5_pulses", DW'(pulses), DW'(0));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // word counter saturation
    for (int k = 0; k < (1 << CW) + 4; k++) beat(k, 4'b0000);
    settle_latch();
    chk("t6_words_sat", DW'(wlat), DW'(12'hFFF));
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    // clear + latch with an error beat in stage 1
    mode = 2'd1;
    for (int k = 0; k < 5; k++) beat(k, 4'b0000);
    beat(5, 4'b0001);
    step(1'b1, 1'b1, mk(6), corrupt(mk(6), 4'b1000), 1'b1, 1'b1);
    chk("t7_latched_words", DW'(wlat), DW'(5));
    chk("t7_latched_errs", DW'(elat), DW'(0));
    chk("t7_fev_cleared", {127'b0, fev}, '0);
    settle_latch();
    chk("t7_words", DW'(wlat), DW'(1));
    chk("t7_index", DW'(fidx), DW'(0));
    chk("t7_lanes", DW'(flanes), DW'(4'b1000));

    // reset while valids high
    reset = 1'b1;
    step(1'b1, 1'b1, mk(1), corrupt(mk(1), 4'b0001), 1'b0, 1'b0);
    step(1'b1, 1'b1, mk(2), corrupt(mk(2), 4'b0001), 1'b0, 1'b0);
    reset = 1'b0;
    idle(3);
    chk("t8_reset_latched", DW'(wlat), '0);
    chk("t8_reset_sticky", {127'b0, sticky}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
